// File: rtl/ps2_pkg.sv
// Shared constants, frame-state encoding and parity helper for the PS/2 scan-code receiver.
package ps2_pkg;

  localparam int CODE_W = 10;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// First-word-fall-through FIFO for decoded scan codes with occupancy count and sticky overflow.
module ps2_code_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = CODE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             valid_r;
  logic             overflow_r;
  logic             full_s;
  logic             pop_s;
  logic             wr_s;
  logic             drop_s;

  assign full_s = (count_r == CNT_W'(DEPTH));
  assign pop_s  = valid_r & pop_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_s   = push & (~full_s | pop_s);
  assign drop_s = push & full_s & ~pop_s;

  // Next occupancy from the write/read strobes.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy, valid flag and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r    <= count_nxt_s;
      valid_r    <= (count_nxt_s != '0);
      overflow_r <= overflow_r | drop_s;
    end
  end

  // Storage array; cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (wr_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head     = mem_r[rd_ptr_r];
  assign valid    = valid_r;
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchroniser, frame FSM, stall watchdog, E0/F0 prefix folding, code FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity does not match.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [CODE_W-1:0]             code_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          err_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic                   fall_s;
  logic                   sample_s;

  frame_state_t state_r;
  frame_state_t state_nxt_s;

  logic [2:0]        bit_cnt_r;
  logic [7:0]        shift_r;
  logic [WD_W-1:0]   wdog_r;
  logic              timeout_s;
  logic              start_s;
  logic              shift_en_s;
  logic              stop_en_s;
  logic              parity_ok_s;
  logic              frame_ok_s;
  logic              frame_bad_s;
  logic              is_ext_s;
  logic              is_brk_s;
  logic              ext_r;
  logic              brk_r;
  logic              push_r;
  logic [CODE_W-1:0] push_code_r;
  logic              err_r;

  // Two-or-more flop synchronisers for the asynchronous PS/2 pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_r  <= '0;
      data_sync_r <= '0;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Newest-but-synchronised stage low while the older stage is still high marks a falling edge.
  assign fall_s   = ~clk_sync_r[SYNC_STAGES-2] & clk_sync_r[SYNC_STAGES-1];
  assign sample_s = data_sync_r[SYNC_STAGES-2];

  assign timeout_s = (state_r != ST_IDLE) && !fall_s && (wdog_r == WD_LAST);

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_nxt_s;
  end

  // Frame sequencing; advances on PS/2 clock falls, watchdog forces a return to idle.
  always_comb begin
    state_nxt_s = state_r;
    if (timeout_s) begin
      state_nxt_s = ST_IDLE;
    end else if (fall_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!sample_s) state_nxt_s = ST_DATA;
          else           state_nxt_s = ST_IDLE;
        end
        ST_DATA: begin
          if (bit_cnt_r == 3'd7) state_nxt_s = ST_PARITY;
          else                   state_nxt_s = ST_DATA;
        end
        ST_PARITY: state_nxt_s = ST_STOP;
        ST_STOP:   state_nxt_s = ST_IDLE;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Per-state strobes for the datapath.
  always_comb begin
    start_s    = 1'b0;
    shift_en_s = 1'b0;
    stop_en_s  = 1'b0;
    case (state_r)
      ST_IDLE:   start_s    = fall_s & ~sample_s;
      ST_DATA:   shift_en_s = fall_s;
      ST_STOP:   stop_en_s  = fall_s;
      default: begin
        start_s    = 1'b0;
        shift_en_s = 1'b0;
        stop_en_s  = 1'b0;
      end
    endcase
  end

  // Data bit counter and LSB-first shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
    end else begin
      if (start_s)         bit_cnt_r <= 3'd0;
      else if (shift_en_s) bit_cnt_r <= bit_cnt_r + 3'd1;
      if (shift_en_s) shift_r <= {sample_s, shift_r[7:1]};
    end
  end

  // Stall watchdog: runs only inside a frame and restarts on every clock fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_r <= '0;
    end else if (fall_s || (state_r == ST_IDLE)) begin
      wdog_r <= '0;
    end else if (wdog_r != WD_LAST) begin
      wdog_r <= wdog_r + WD_W'(1);
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic parity_r;

  // Captured parity bit for the stop-bit check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_r <= 1'b0;
    end else if ((state_r == ST_PARITY) && fall_s) begin
      parity_r <= sample_s;
    end
  end

  assign parity_ok_s = odd_parity_ok(shift_r, parity_r);
`else
  assign parity_ok_s = 1'b1;
`endif

  assign frame_ok_s  = stop_en_s & sample_s & parity_ok_s;
  assign frame_bad_s = stop_en_s & ~(sample_s & parity_ok_s);
  assign is_ext_s    = (shift_r == PS2_PREFIX_EXT);
  assign is_brk_s    = (shift_r == PS2_PREFIX_BRK);

  // Prefix folding, push strobe and error pulse; any error drops pending prefixes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_r       <= 1'b0;
      brk_r       <= 1'b0;
      push_r      <= 1'b0;
      push_code_r <= '0;
      err_r       <= 1'b0;
    end else begin
      err_r       <= frame_bad_s | timeout_s;
      push_r      <= frame_ok_s & ~is_ext_s & ~is_brk_s;
      push_code_r <= {ext_r, brk_r, shift_r};
      if (frame_ok_s) begin
        if (is_ext_s) begin
          ext_r <= 1'b1;
        end else if (is_brk_s) begin
          brk_r <= 1'b1;
        end else begin
          ext_r <= 1'b0;
          brk_r <= 1'b0;
        end
      end else if (frame_bad_s || timeout_s) begin
        ext_r <= 1'b0;
        brk_r <= 1'b0;
      end
    end
  end

  ps2_code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_r),
    .push_data (push_code_r),
    .pop_ready (ready_i),
    .head      (code_o),
    .valid     (valid_o),
    .count     (count_o),
    .overflow  (overflow_o)
  );

  assign err_o = err_r;

endmodule
